// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : First-word-fall-through byte FIFO placed in front of a UART
//                transmitter. Reports level (count, empty, almost_full,
//                full) and keeps a sticky overflow flag for writes that were
//                attempted while full. The head byte is presented on
//                tx_valid/tx_data and leaves when the transmitter raises
//                tx_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter  int DEPTH    = 16,                 // power of two, >= 2
    parameter  int AF_LEVEL = 12,                 // 1..DEPTH
    localparam int CW       = $clog2(DEPTH) + 1   // count width, derived
) (
    input  logic          clk,
    input  logic          rst_n,

    // Host write side
    input  logic          wr_en,
    input  logic [7:0]    wr_data,

    // Level / status
    output logic          full,
    output logic          almost_full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    input  logic          ovf_clr,

    // Transmitter side
    output logic          tx_valid,
    output logic [7:0]    tx_data,
    input  logic          tx_ready
);

    // Pointer width; pointers wrap naturally because DEPTH is a power of two.
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] C_PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] C_CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] C_CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] C_CNT_AF    = CW'(AF_LEVEL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    // ------------------------------------------------------------------
    // Transfer qualifiers
    // ------------------------------------------------------------------
    // A write while full is dropped even if a pop happens on the same edge:
    // the decision is made on the current (registered) full flag only.
    logic w_push;
    logic w_pop;
    logic w_reject;

    assign w_push   = wr_en & ~full;
    assign w_pop    = tx_valid & tx_ready;
    assign w_reject = wr_en & full;

    // ------------------------------------------------------------------
    // Flag decodes from the registered count
    // ------------------------------------------------------------------
    assign count       = r_count;
    assign empty       = (r_count == '0);
    assign full        = (r_count == C_CNT_FULL);
    assign almost_full = (r_count >= C_CNT_AF);
    assign overflow    = r_overflow;

    // Head byte falls through as soon as the FIFO is non-empty; the data bus
    // is forced to zero when nothing is valid so idle output is deterministic.
    assign tx_valid = ~empty;
    assign tx_data  = tx_valid ? r_mem[r_rd_ptr] : 8'h00;

    // Storage array: written on accepted pushes only, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Write pointer advances on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        end
    end

    // Read pointer advances on every handshake with the transmitter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        end
    end

    // Occupancy count: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a rejected write takes priority over a clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_reject) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Directed self-checking bench for uart_tx_fifo. Inputs are
//                driven and outputs sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int CW       = 5;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          almost_full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          ovf_clr;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;

    int n_cmp;
    int n_err;

    uart_tx_fifo #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready)
    );

    // 100 MHz-style clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {tx_valid, tx_data}, {1'b1, exp});
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
    endtask

    initial begin
        logic stable;
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        ovf_clr  = 1'b0;
        tx_ready = 1'b0;
        step();
        step();

        // ---------------- reset values ----------------
        check("rst_count",    count, 0);
        check("rst_empty",    empty, 1);
        check("rst_full",     full, 0);
        check("rst_af",       almost_full, 0);
        check("rst_ovf",      overflow, 0);
        check("rst_txvalid",  tx_valid, 0);
        check("rst_txdata",   tx_data, 8'h00);
        rst_n = 1'b1;
        step();

        // ---------------- 1: single byte, held then popped ----------------
        wr_en   = 1'b1;
        wr_data = 8'hF3;
        check("t1_empty_before", empty, 1);
        step();
        wr_en = 1'b0;
        check("t1_count", count, 1);
        check("t1_empty_after", empty, 0);
        check("t1_head", {tx_valid, tx_data}, {1'b1, 8'hF3});
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!(tx_valid === 1'b1 && tx_data === 8'hF3 && count === 5'd1)) stable = 1'b0;
        end
        check("t1_stable_100", stable, 1);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("t1_count_after_pop", count, 0);
        check("t1_txvalid_after_pop", tx_valid, 0);
        check("t1_txdata_idle", tx_data, 8'h00);
        // tx_ready while empty is ignored
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("t1_pop_empty_count", count, 0);

        // ---------------- 2: burst to full, overflow, drain ----------------
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            check($sformatf("t2_count_%0d", i + 1), count, i + 1);
            check($sformatf("t2_af_%0d", i + 1), almost_full, (i + 1 >= 12) ? 1 : 0);
            check($sformatf("t2_full_%0d", i + 1), full, (i + 1 == 16) ? 1 : 0);
        end
        push(8'hAA);
        check("t2_ovf", overflow, 1);
        check("t2_count_full", count, 16);
        check("t2_head_unchanged", tx_data, 8'h00);
        for (int i = 0; i < 16; i++) begin
            pop_check($sformatf("t2_drain_%0d", i), 8'(i));
        end
        check("t2_empty_end", empty, 1);
        check("t2_ovf_sticky", overflow, 1);

        // ---------------- 5a: clear with no write ----------------
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t5_clear", overflow, 0);

        // ---------------- 3: wrap-around ----------------
        for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
        for (int i = 0; i < 10; i++) pop_check($sformatf("t3_first_%0d", i), 8'h30 + 8'(i));
        for (int i = 0; i < 10; i++) push(8'h50 + 8'(i));
        check("t3_count", count, 10);
        for (int i = 0; i < 10; i++) pop_check($sformatf("t3_wrap_%0d", i), 8'h50 + 8'(i));
        check("t3_empty", empty, 1);

        // ---------------- 4: simultaneous push/pop ----------------
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t4_sim_head_%0d", i), tx_data, 8'h60 + 8'(i));
            wr_en    = 1'b1;
            wr_data  = 8'h65 + 8'(i);
            tx_ready = 1'b1;
            step();
            wr_en    = 1'b0;
            tx_ready = 1'b0;
            check($sformatf("t4_sim_count_%0d", i), count, 5);
        end
        for (int i = 0; i < 5; i++) pop_check($sformatf("t4_order_%0d", i), 8'h63 + 8'(i));
        check("t4_empty", empty, 1);
        // push+pop while full: write rejected, pop still happens
        for (int i = 0; i < 16; i++) push(8'h70 + 8'(i));
        check("t4_full", full, 1);
        wr_en    = 1'b1;
        wr_data  = 8'hEE;
        tx_ready = 1'b1;
        step();
        wr_en    = 1'b0;
        tx_ready = 1'b0;
        check("t4_full_pushpop_count", count, 15);
        check("t4_full_pushpop_ovf", overflow, 1);
        for (int i = 1; i < 16; i++) pop_check($sformatf("t4_full_drain_%0d", i), 8'h70 + 8'(i));
        check("t4_full_drain_empty", empty, 1);

        // ---------------- 5b: clear and rejected write together ----------------
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t5_clear2", overflow, 0);
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        wr_en   = 1'b1;
        wr_data = 8'hCC;
        ovf_clr = 1'b1;
        step();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        check("t5_set_wins", overflow, 1);
        check("t5_count", count, 16);

        // ---------------- 6: asynchronous reset mid-operation ----------------
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("t6_after_rst_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) push(8'h91 + 8'(i));
        check("t6_loaded", count, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_txvalid", tx_valid, 0);
        check("t6_async_count", count, 0);
        check("t6_async_empty", empty, 1);
        step();
        rst_n = 1'b1;
        step();
        push(8'hEB);
        check("t6_new_head", {tx_valid, tx_data}, {1'b1, 8'hEB});
        check("t6_new_count", count, 1);
        pop_check("t6_pop", 8'hEB);
        check("t6_empty_end", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
